// File: rtl/reciprocal_nr.sv
// rtl/reciprocal_nr.sv - sequential unsigned fixed-point reciprocal by Newton-Raphson iteration
module reciprocal_nr #(
    parameter int IN_W     = 18,
    parameter int IN_FRAC  = 17,
    parameter int OUT_W    = 36,
    parameter int OUT_FRAC = 34,
    parameter int NR_ITERS = 4,
    parameter int WORK_W   = 40
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [IN_W-1:0]   i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OUT_W-1:0]  o_recip,
    output logic              o_sat,
    output logic              o_div0
);

    // Mantissa, estimate and correction term all share one UQ2.FRAC format.
    localparam int FRAC  = WORK_W - 2;
    localparam int LZ_W  = $clog2(IN_W + 1);
    localparam int DW    = WORK_W + OUT_W + 1;
    localparam int CNT_W = 3;

    // Seed line x0 = 48/17 - 32/17*m, constants truncated to the working format.
    localparam logic [WORK_W+5:0] SEED_A_W = ((WORK_W+6)'(48) << FRAC) / (WORK_W+6)'(17);
    localparam logic [WORK_W+5:0] SEED_B_W = ((WORK_W+6)'(32) << FRAC) / (WORK_W+6)'(17);
    localparam logic [WORK_W-1:0] SEED_A   = SEED_A_W[WORK_W-1:0];
    localparam logic [WORK_W-1:0] SEED_B   = SEED_B_W[WORK_W-1:0];
    localparam logic [WORK_W-1:0] TWO      = {2'b10, {FRAC{1'b0}}};
    localparam logic [WORK_W-1:0] ONE_LSB  = {{(WORK_W-1){1'b0}}, 1'b1};

    // Final scaling shift = e + OUT_FRAC - FRAC, where e = IN_FRAC + lz - IN_W.
    localparam logic signed [15:0] SH_BIAS = 16'(IN_FRAC - IN_W + OUT_FRAC - FRAC);
    localparam logic signed [15:0] SH_MAX  = 16'(OUT_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ITER_A,
        S_ITER_B,
        S_DENORM,
        S_DONE
    } state_t;

    state_t                state;
    logic [IN_W-1:0]       data_q;
    logic [WORK_W-1:0]     m_q;
    logic [WORK_W-1:0]     x_q;
    logic [WORK_W-1:0]     t_q;
    logic signed [15:0]    sh_q;
    logic [CNT_W-1:0]      iter_cnt;

    logic [LZ_W-1:0]       lz;
    logic [IN_W-1:0]       mn;
    logic [WORK_W-1:0]     m_next;
    logic [2*WORK_W-1:0]   seed_prod;
    logic [WORK_W-1:0]     x0;
    logic [WORK_W-1:0]     mul_b;
    logic [2*WORK_W-1:0]   mul_prod;
    logic [WORK_W-1:0]     mul_trunc;

    logic [DW-1:0]         wide;
    logic [15:0]           rs;
    logic [WORK_W-1:0]     rmask;
    logic                  rbit;
    logic [WORK_W:0]       rnd;
    logic [OUT_W-1:0]      den_val;
    logic                  den_sat;

    function automatic logic [LZ_W-1:0] count_lz(input logic [IN_W-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + LZ_W'(1);
            end
        end
        return n;
    endfunction

    // Normalisation: shift the operand so its top bit is set, giving m in [0.5,1).
    assign lz        = count_lz(data_q);
    assign mn        = data_q << lz;
    assign m_next    = {{(WORK_W-IN_W){1'b0}}, mn} << (FRAC - IN_W);
    assign seed_prod = {{WORK_W{1'b0}}, SEED_B} * {{WORK_W{1'b0}}, m_next};
    assign x0        = SEED_A - WORK_W'(seed_prod >> FRAC);

    // One multiplier serves both halves of an iteration: m*x, then x*t.
    assign mul_b     = (state == S_ITER_A) ? m_q : t_q;
    assign mul_prod  = {{WORK_W{1'b0}}, x_q} * {{WORK_W{1'b0}}, mul_b};
    assign mul_trunc = WORK_W'(mul_prod >> FRAC);

    // Denormalise the estimate to the output format with round-half-up and saturation.
    always_comb begin
        wide    = '0;
        rs      = '0;
        rmask   = '0;
        rbit    = 1'b0;
        rnd     = '0;
        den_val = '0;
        den_sat = 1'b0;
        if (!sh_q[15]) begin
            wide    = {{(OUT_W+1){1'b0}}, x_q} << sh_q;
            den_sat = (sh_q > SH_MAX) || (|wide[DW-1:OUT_W]);
            den_val = wide[OUT_W-1:0];
        end else begin
            rs      = -sh_q;
            rmask   = ONE_LSB << (rs - 16'd1);
            rbit    = |(x_q & rmask);
            rnd     = {1'b0, x_q >> rs} + {{WORK_W{1'b0}}, rbit};
            den_sat = |rnd[WORK_W:OUT_W];
            den_val = rnd[OUT_W-1:0];
        end
        if (den_sat) den_val = '1;
    end

    // Control FSM with registered handshake outputs and result holding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            o_ready  <= 1'b0;
            o_valid  <= 1'b0;
            o_recip  <= '0;
            o_sat    <= 1'b0;
            o_div0   <= 1'b0;
            data_q   <= '0;
            m_q      <= '0;
            x_q      <= '0;
            t_q      <= '0;
            sh_q     <= '0;
            iter_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (o_ready && i_valid) begin
                        o_ready <= 1'b0;
                        data_q  <= i_data;
                        state   <= S_NORM;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                S_NORM: begin
                    if (data_q == '0) begin
                        o_recip <= '1;
                        o_sat   <= 1'b1;
                        o_div0  <= 1'b1;
                        o_valid <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        m_q      <= m_next;
                        x_q      <= x0;
                        sh_q     <= SH_BIAS + 16'(lz);
                        iter_cnt <= '0;
                        state    <= S_ITER_A;
                    end
                end
                S_ITER_A: begin
                    t_q   <= TWO - mul_trunc;
                    state <= S_ITER_B;
                end
                S_ITER_B: begin
                    x_q <= mul_trunc;
                    if (iter_cnt == CNT_W'(NR_ITERS - 1)) begin
                        state <= S_DENORM;
                    end else begin
                        iter_cnt <= iter_cnt + CNT_W'(1);
                        state    <= S_ITER_A;
                    end
                end
                S_DENORM: begin
                    o_recip <= den_val;
                    o_sat   <= den_sat;
                    o_div0  <= 1'b0;
                    o_valid <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reciprocal_nr.sv
// tb/tb_reciprocal_nr.sv - randomized self-checking bench for reciprocal_nr
module tb_reciprocal_nr;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [17:0] i_data = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [35:0] o_recip;
    logic        o_sat;
    logic        o_div0;

    int n_checks = 0;
    int n_fail   = 0;

    localparam longint unsigned ALL_ONES = 64'hF_FFFF_FFFF;

    reciprocal_nr dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_recip (o_recip),
        .o_sat   (o_sat),
        .o_div0  (o_div0)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input longint unsigned obs,
                         input longint unsigned exp, input longint unsigned tol);
        longint unsigned diff;
        diff = (obs > exp) ? obs - exp : exp - obs;
        n_checks++;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Reference: round(2^34 / (d / 2^17)) = round(2^51 / d), saturating at 2^36.
    function automatic longint unsigned model_recip(input logic [17:0] d,
                                                    output logic sat, output logic div0);
        longint unsigned q;
        div0 = (d == 0);
        if (div0) begin
            sat = 1'b1;
            return ALL_ONES;
        end
        q = ((64'd1 << 52) / 64'(d) + 64'd1) >> 1;
        if (q >= (64'd1 << 36)) begin
            sat = 1'b1;
            return ALL_ONES;
        end
        sat = 1'b0;
        return q;
    endfunction

    task automatic start_op(input logic [17:0] d);
        int guard;
        guard = 0;
        @(negedge i_clk);
        while (!o_ready && guard < 60) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_ready) check("ready_timeout", 64'(o_ready), 64'd1, 0);
        i_valid = 1'b1;
        i_data  = d;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_data  = 18'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        if (!o_valid) check("valid_timeout", 64'(o_valid), 64'd1, 0);
    endtask

    task automatic consume();
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [17:0] d, input longint unsigned exp,
                            input longint unsigned tol, input logic exp_sat,
                            input logic exp_div0, input int exp_lat);
        int lat;
        start_op(d);
        wait_result(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat), 0);
        check({tag, "_recip"}, 64'(o_recip), exp, tol);
        check({tag, "_sat"}, 64'(o_sat), 64'(exp_sat), 0);
        check({tag, "_div0"}, 64'(o_div0), 64'(exp_div0), 0);
        consume();
        check({tag, "_done"}, 64'({o_valid, o_ready}), 64'b01, 0);
    endtask

    initial begin
        int              lat;
        logic            ok;
        longint unsigned r0;
        logic            s0, z0;
        logic [17:0]     d;
        longint unsigned exp_r;
        logic            exp_s, exp_z;
        longint unsigned err, max_err;
        real             pct_sum, ideal;
        int              n_norm;

        // Reset state and registered o_ready rise
        #2 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_outputs", 64'({o_ready, o_valid, o_sat, o_div0, o_recip}), 64'd0, 0);
        i_rst_n = 1'b1;
        #1;
        check("rst_rel_ready0", 64'(o_ready), 64'd0, 0);
        @(posedge i_clk);
        #1;
        check("rst_rel_ready1", 64'(o_ready), 64'd1, 0);

        // Directed operands
        directed("one",     18'h20000, 64'h4_0000_0000, 0, 1'b0, 1'b0, 10);
        directed("half",    18'h10000, 64'h8_0000_0000, 0, 1'b0, 1'b0, 10);
        directed("max",     18'h3FFFF, 64'h2_0000_8000, 2, 1'b0, 1'b0, 10);
        directed("quarter", 18'h08000, ALL_ONES,        0, 1'b1, 1'b0, 10);
        directed("lsb",     18'h00001, ALL_ONES,        0, 1'b1, 1'b0, 10);
        directed("zero",    18'h00000, ALL_ONES,        0, 1'b1, 1'b1, 1);

        // Backpressure: result and flags hold, second operand refused
        start_op(18'h20000);
        wait_result(lat);
        r0 = 64'(o_recip);
        s0 = o_sat;
        z0 = o_div0;
        check("bp_value", r0, 64'h4_0000_0000, 0);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = 18'h10000;
        ok = 1'b1;
        repeat (20) begin
            @(negedge i_clk);
            if (64'(o_recip) != r0 || o_sat != s0 || o_div0 != z0 || !o_valid || o_ready)
                ok = 1'b0;
        end
        check("bp_stable", 64'(ok), 64'd1, 0);
        i_valid = 1'b0;
        consume();
        check("bp_release", 64'({o_valid, o_ready}), 64'b01, 0);
        ok = 1'b1;
        repeat (15) begin
            @(negedge i_clk);
            if (o_valid || !o_ready) ok = 1'b0;
        end
        check("bp_single_hs", 64'(ok), 64'd1, 0);

        // Reset during iteration
        start_op(18'h2ABCD);
        repeat (4) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({o_ready, o_valid, o_sat, o_div0, o_recip}), 64'd0, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        ok = 1'b1;
        repeat (15) begin
            @(negedge i_clk);
            if (o_valid) ok = 1'b0;
        end
        check("midrst_no_valid", 64'(ok), 64'd1, 0);
        directed("after_rst", 18'h3FFFF, 64'h2_0000_8000, 2, 1'b0, 1'b0, 10);

        // Random operands against the arithmetic model
        max_err = 0;
        pct_sum = 0.0;
        n_norm  = 0;
        for (int i = 0; i < 1024; i++) begin
            d = 18'($urandom);
            if ($urandom_range(0, 31) == 0) d = 18'd0;
            else if ($urandom_range(0, 7) == 0) d = 18'($urandom_range(1, 32'h8000));
            exp_r = model_recip(d, exp_s, exp_z);
            start_op(d);
            wait_result(lat);
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            check("rnd_recip", 64'(o_recip), exp_r, exp_s ? 0 : 2);
            check("rnd_sat", 64'(o_sat), 64'(exp_s), 0);
            check("rnd_div0", 64'(o_div0), 64'(exp_z), 0);
            if (!exp_s) begin
                err = (64'(o_recip) > exp_r) ? 64'(o_recip) - exp_r : exp_r - 64'(o_recip);
                if (err > max_err) max_err = err;
                ideal = (2.0 ** 51) / real'(d);
                pct_sum += ((real'(o_recip) > ideal) ? real'(o_recip) - ideal
                                                     : ideal - real'(o_recip)) / ideal * 100.0;
                n_norm++;
            end
            consume();
        end
        $display("Random operands: %0d normal, max error %0d LSB, average error %e %%",
                 n_norm, max_err, (n_norm > 0) ? pct_sum / real'(n_norm) : 0.0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
